// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller: FSM states,
// opcode/funct constants, ALU/EXT/NPC select codes and the decode-dispatch helper.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StExecI,
    StAddr,
    StMemRd,
    StMemWr,
    StWbAlu,
    StWbMem,
    StBranch,
    StJump,
    StTrap
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluSlt = 4'd4,
    AluLui = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    ExtZero  = 2'b00,
    ExtSign  = 2'b01,
    ExtUpper = 2'b10
  } ext_op_e;

  typedef enum logic [1:0] {
    NpcPc4    = 2'b00,
    NpcBranch = 2'b01,
    NpcJump   = 2'b10
  } npc_op_e;

  // First execution state for a freshly fetched instruction; unsupported encodings trap.
  function automatic state_e decode_state(logic [5:0] op, logic [5:0] funct);
    state_e st;
    unique case (op)
      OpRtype: begin
        unique case (funct)
          FnAddu, FnSubu, FnAnd, FnOr, FnSlt: st = StExecR;
          default:                            st = StTrap;
        endcase
      end
      OpAddiu, OpOri, OpLui: st = StExecI;
      OpLw, OpSw:            st = StAddr;
      OpBeq:                 st = StBranch;
      OpJ:                   st = StJump;
      default:               st = StTrap;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational op/funct to ALU operation decoder, shared by the R-type,
// immediate and branch execution phases.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output alu_op_e    alu_op
);

  always_comb begin
    alu_op = AluAdd;
    if (op == OpRtype) begin
      case (funct)
        FnSubu:  alu_op = AluSub;
        FnAnd:   alu_op = AluAnd;
        FnOr:    alu_op = AluOr;
        FnSlt:   alu_op = AluSlt;
        default: alu_op = AluAdd;
      endcase
    end else begin
      case (op)
        OpOri:   alu_op = AluOr;
        OpLui:   alu_op = AluLui;
        OpBeq:   alu_op = AluSub;
        default: alu_op = AluAdd;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore sequencing controller for the MIPS datapath: steps each
// instruction through its phases, gates PC/IR/RF/DM writes and waits on mem_rdy.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          HAS_WAIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic [1:0]       npc_op,
  output logic             reg_w,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem2r,
  output logic             mem_r,
  output logic             mem_w,
  output logic [1:0]       ext_op,
  output logic [3:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, funct_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             rdy;
  logic             retire;
  alu_op_e          dec_alu_op;

  assign rdy = HAS_WAIT ? mem_rdy : 1'b1;

  mc_alu_dec u_alu_dec (
    .op     (op_q),
    .funct  (funct_q),
    .alu_op (dec_alu_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = decode_state(op, funct);
      StExecR,
      StExecI:  state_d = StWbAlu;
      StAddr:   state_d = (op_q == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (rdy) state_d = StWbMem;
      end
      StMemWr: begin
        if (rdy) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StWbAlu, StWbMem, StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state_q == StDecode) begin
        op_q    <= op;
        funct_q <= funct;
      end
      if (state_q == StDecode && state_d == StTrap) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    npc_op  = NpcPc4;
    reg_w   = 1'b0;
    reg_dst = 1'b0;
    alu_src = 1'b0;
    mem2r   = 1'b0;
    mem_r   = 1'b0;
    mem_w   = 1'b0;
    ext_op  = ExtZero;
    alu_op  = AluAdd;
    case (state_q)
      StFetch: begin
        pc_wr = 1'b1;
        ir_wr = 1'b1;
      end
      StExecR: alu_op = dec_alu_op;
      StExecI: begin
        alu_src = 1'b1;
        alu_op  = dec_alu_op;
        if (op_q == OpOri)      ext_op = ExtZero;
        else if (op_q == OpLui) ext_op = ExtUpper;
        else                    ext_op = ExtSign;
      end
      StAddr: begin
        alu_src = 1'b1;
        ext_op  = ExtSign;
        alu_op  = AluAdd;
      end
      // Only the request is held while stalled so the registered address stays put.
      StMemRd: mem_r = 1'b1;
      StMemWr: mem_w = 1'b1;
      StWbAlu: begin
        reg_w   = 1'b1;
        reg_dst = (op_q == OpRtype);
      end
      StWbMem: begin
        reg_w = 1'b1;
        mem2r = 1'b1;
      end
      StBranch: begin
        alu_op = dec_alu_op;
        npc_op = NpcBranch;
        pc_wr  = zero;
      end
      StJump: begin
        pc_wr  = 1'b1;
        npc_op = NpcJump;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: a per-instruction phase model expands each instruction into
// expected per-cycle control vectors, which are compared against the DUT.
module tb_mc_ctrl;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic [1:0] npc_op;
    logic       reg_w;
    logic       reg_dst;
    logic       alu_src;
    logic       mem2r;
    logic       mem_r;
    logic       mem_w;
    logic [1:0] ext_op;
    logic [3:0] alu_op;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t       o;
    logic        rdy;
    logic        zero;
    logic [5:0]  op;
    logic [5:0]  funct;
    int unsigned ret;
  } step_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = '0, funct = '0;
  logic        zero = 1'b0, mem_rdy = 1'b0;
  logic        pc_wr, ir_wr, reg_w, reg_dst, alu_src, mem2r, mem_r, mem_w, illegal;
  logic [1:0]  npc_op, ext_op;
  logic [3:0]  alu_op;
  logic [31:0] retired;
  outs_t       obs;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned model_ret = 0;
  step_t       exp_q[$];

  always #5 clk = ~clk;

  mc_ctrl #(
    .CNT_W    (32),
    .HAS_WAIT (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .funct   (funct),
    .zero    (zero),
    .mem_rdy (mem_rdy),
    .pc_wr   (pc_wr),
    .ir_wr   (ir_wr),
    .npc_op  (npc_op),
    .reg_w   (reg_w),
    .reg_dst (reg_dst),
    .alu_src (alu_src),
    .mem2r   (mem2r),
    .mem_r   (mem_r),
    .mem_w   (mem_w),
    .ext_op  (ext_op),
    .alu_op  (alu_op),
    .illegal (illegal),
    .retired (retired)
  );

  assign obs = {pc_wr, ir_wr, npc_op, reg_w, reg_dst, alu_src, mem2r, mem_r, mem_w,
                ext_op, alu_op, illegal};

  task automatic check_outs(string tag, outs_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s outs: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_ret(string tag, int unsigned exp);
    vectors++;
    assert (retired === 32'(exp)) else begin
      miscompares++;
      $error("FAIL %s retired: observed %0d required %0d", tag, retired, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(outs_t o, logic rdy, logic z, logic [5:0] iop, logic [5:0] ifn);
    step_t s;
    s.o = o; s.rdy = rdy; s.zero = z; s.op = iop; s.funct = ifn; s.ret = model_ret;
    exp_q.push_back(s);
  endfunction

  function automatic outs_t fetch_rec();
    outs_t r = '0;
    r.pc_wr = 1'b1;
    r.ir_wr = 1'b1;
    return r;
  endfunction

  // Expected cycle-by-cycle control for one instruction, straight from the phase tables.
  function automatic void gen_instr(logic [5:0] iop, logic [5:0] ifn, logic z, int nstall);
    outs_t r;
    int    rcode;
    push(fetch_rec(), rbit(), rbit(), iop, ifn);
    push('0, rbit(), rbit(), iop, ifn);
    rcode = -1;
    if (iop == 6'b000000) begin
      case (ifn)
        6'b100001: rcode = 0;
        6'b100011: rcode = 1;
        6'b100100: rcode = 2;
        6'b100101: rcode = 3;
        6'b101010: rcode = 4;
        default:   rcode = -1;
      endcase
    end
    r = '0;
    if (rcode >= 0) begin
      r.alu_op = 4'(rcode);
      push(r, rbit(), rbit(), iop, ifn);
      r = '0; r.reg_w = 1'b1; r.reg_dst = 1'b1;
      push(r, rbit(), rbit(), iop, ifn);
      model_ret++;
    end else if (iop == 6'b001001 || iop == 6'b001101 || iop == 6'b001111) begin
      r.alu_src = 1'b1;
      if (iop == 6'b001001) begin r.ext_op = 2'b01; r.alu_op = 4'd0; end
      if (iop == 6'b001101) begin r.ext_op = 2'b00; r.alu_op = 4'd3; end
      if (iop == 6'b001111) begin r.ext_op = 2'b10; r.alu_op = 4'd5; end
      push(r, rbit(), rbit(), iop, ifn);
      r = '0; r.reg_w = 1'b1;
      push(r, rbit(), rbit(), iop, ifn);
      model_ret++;
    end else if (iop == 6'b100011 || iop == 6'b101011) begin
      r.alu_src = 1'b1; r.ext_op = 2'b01;
      push(r, rbit(), rbit(), iop, ifn);
      r = '0;
      if (iop == 6'b100011) r.mem_r = 1'b1;
      else                  r.mem_w = 1'b1;
      for (int i = 0; i < nstall; i++) push(r, 1'b0, rbit(), iop, ifn);
      push(r, 1'b1, rbit(), iop, ifn);
      if (iop == 6'b100011) begin
        r = '0; r.reg_w = 1'b1; r.mem2r = 1'b1;
        push(r, rbit(), rbit(), iop, ifn);
      end
      model_ret++;
    end else if (iop == 6'b000100) begin
      r.pc_wr = z; r.npc_op = 2'b01; r.alu_op = 4'd1;
      push(r, rbit(), z, iop, ifn);
      model_ret++;
    end else if (iop == 6'b000010) begin
      r.pc_wr = 1'b1; r.npc_op = 2'b10;
      push(r, rbit(), rbit(), iop, ifn);
      model_ret++;
    end else begin
      r.illegal = 1'b1;
      for (int i = 0; i < 12; i++) push(r, rbit(), rbit(), iop, ifn);
    end
  endfunction

  task automatic run(int n);
    step_t s;
    int    k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      s = exp_q.pop_front();
      @(negedge clk);
      op = s.op; funct = s.funct; mem_rdy = s.rdy; zero = s.zero;
      #1;
      check_outs($sformatf("op=%b fn=%b step%0d", s.op, s.funct, k), s.o);
      check_ret($sformatf("op=%b fn=%b step%0d", s.op, s.funct, k), s.ret);
      k++;
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    model_ret = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs({tag, " reset"}, fetch_rec());
    check_ret({tag, " reset"}, 0);
    rst = 1'b0;
  endtask

  task automatic rand_instr();
    logic [5:0] fn = 6'($urandom);
    int         nst = $urandom_range(0, 3);
    logic       z = rbit();
    case ($urandom_range(0, 11))
      0:  gen_instr(6'b000000, 6'b100001, z, nst);
      1:  gen_instr(6'b000000, 6'b100011, z, nst);
      2:  gen_instr(6'b000000, 6'b100100, z, nst);
      3:  gen_instr(6'b000000, 6'b100101, z, nst);
      4:  gen_instr(6'b000000, 6'b101010, z, nst);
      5:  gen_instr(6'b001001, fn, z, nst);
      6:  gen_instr(6'b001101, fn, z, nst);
      7:  gen_instr(6'b001111, fn, z, nst);
      8:  gen_instr(6'b100011, fn, z, nst);
      9:  gen_instr(6'b101011, fn, z, nst);
      10: gen_instr(6'b000100, fn, z, nst);
      default: gen_instr(6'b000010, fn, z, nst);
    endcase
    run(-1);
  endtask

  initial begin
    do_reset("initial");

    gen_instr(6'b000000, 6'b100001, 1'b0, 0); run(-1);  // addu
    gen_instr(6'b100011, 6'b000000, 1'b0, 2); run(-1);  // lw, two stall cycles
    gen_instr(6'b000100, 6'b000000, 1'b1, 0); run(-1);  // beq taken
    gen_instr(6'b000100, 6'b000000, 1'b0, 0); run(-1);  // beq not taken
    gen_instr(6'b001101, 6'b010101, 1'b0, 0); run(-1);  // ori
    gen_instr(6'b001111, 6'b101010, 1'b0, 0); run(-1);  // lui
    gen_instr(6'b101011, 6'b000000, 1'b0, 1); run(-1);  // sw
    gen_instr(6'b000010, 6'b000000, 1'b0, 0); run(-1);  // j

    for (int i = 0; i < 40; i++) rand_instr();

    // Async reset while a store is stalled: enables must drop before the next edge.
    gen_instr(6'b101011, 6'b000000, 1'b0, 4);
    run(5);
    exp_q.delete();
    #1 rst = 1'b1;
    model_ret = 0;
    #1;
    check_outs("async_rst mid-sw", fetch_rec());
    check_ret("async_rst mid-sw", 0);
    @(posedge clk);
    #1 rst = 1'b0;
    gen_instr(6'b000000, 6'b101010, 1'b0, 0); run(-1);

    gen_instr(6'b111111, 6'b000000, 1'b0, 0); run(-1);  // unsupported opcode
    do_reset("after trap op");
    gen_instr(6'b000000, 6'b000000, 1'b0, 0); run(-1);  // unsupported funct
    do_reset("after trap funct");

    for (int i = 0; i < 8; i++) rand_instr();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencing controller for the MIPS datapath: PC, instruction memory, RF, EXT, ALU, data memory and the two 2:1 muxes. It replaces the single-cycle combinational decode with a Moore FSM that runs each instruction over 3–5+ cycles. It also gates PC/IR/RF/DM writes per phase and waits on a data-memory ready handshake. The datapath adds an IR register and A/B/ALUOut/MDR holding registers, all enabled by this block.

Parameters:
CNT_W, 32, width of retired-instruction counter
HAS_WAIT, 1, 1 = honour mem_rdy; 0 = treat mem_rdy as constant 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
op  in  6  IR[31:26], valid from the DECODE cycle onward
funct  in  6  IR[5:0]
zero  in  1  ALU Zero flag
mem_rdy  in  1  data memory completes access this cycle
pc_wr  out  1  PC load enable
ir_wr  out  1  IR load enable
npc_op  out  2  00 PC+4, 01 branch, 10 jump
reg_w  out  1  RF write enable
reg_dst  out  1  1 = rd, 0 = rt
alu_src  out  1  1 = EXT immediate, 0 = RD2
mem2r  out  1  1 = MDR to RF, 0 = ALUOut to RF
mem_r  out  1  data memory read request
mem_w  out  1  data memory write request
ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
alu_op  out  4  ALU operation code
illegal  out  1  sticky: unsupported opcode/funct seen
retired  out  CNT_W  count of completed instructions

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. During reset: state=FETCH, latched op/funct=0, illegal=0, retired=0.
- All outputs decode from the current state and the op/funct latched in DECODE (Moore). Inactive enables are 0. Unused selects are 0.
- FETCH: ir_wr=1, pc_wr=1, npc_op=00. Next state DECODE.
- DECODE: latch op/funct. Next state by opcode:
  - R-type (op 000000), funct addu 100001, subu 100011, and 100100, or 100101, slt 101010 -> EXEC_R
  - addiu 001001, ori 001101, lui 001111 -> EXEC_I
  - lw 100011, sw 101011 -> ADDR
  - beq 000100 -> BRANCH
  - j 000010 -> JUMP
  - anything else -> TRAP
- EXEC_R: alu_src=0, alu_op from funct. Next WB_ALU with reg_dst=1.
- EXEC_I: alu_src=1. addiu: ext=01, ADD. ori: ext=00, OR. lui: ext=10, ADD (ALU A forced by datapath irrelevant; spec: alu_op=LUI passes B). Next WB_ALU with reg_dst=0.
- ADDR: alu_src=1, ext=01, alu_op=ADD. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: mem_r=1 held until mem_rdy=1, then WB_MEM.
- MEM_WR: mem_w=1 held until mem_rdy=1, then FETCH and retire.
- While waiting in MEM_RD/MEM_WR, all other enables stay 0. The address must stay stable; ALUOut is not re-enabled.
- WB_ALU: reg_w=1, mem2r=0. WB_MEM: reg_w=1, mem2r=1, reg_dst=0. Both go to FETCH and retire.
- BRANCH: alu_src=0, alu_op=SUB, npc_op=01, pc_wr=zero. Next FETCH and retire.
- JUMP: pc_wr=1, npc_op=10. Next FETCH and retire.
- TRAP: illegal set to 1. All enables 0. The FSM stays in TRAP until reset.
- Retire: retired increments by 1 on the cycle leaving a final state. It wraps modulo 2^CNT_W.
- Cycle counts with no wait states: R/I = 4, lw = 5, sw = 4, beq = 3, j = 3. Each mem_rdy=0 cycle adds 1.
- Reset asserted mid-instruction: the FSM aborts immediately to FETCH and all enables drop at once. A partial write must not complete on the following edge.
- HAS_WAIT=0: MEM_RD and MEM_WR last exactly one cycle.

Decomposition:
Shared package mc_pkg holds:
- state encoding: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP
- opcode/funct constants
- ALU codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5
- EXT codes and NPC codes

Sub-module mc_alu_dec is the combinational funct/op-to-alu_op decoder. It is reused by EXEC_R, EXEC_I and BRANCH.

Test Plan:
- Reset, then addu (op=0, funct=100001), mem_rdy=1 -> pc_wr/ir_wr in cycle 0, reg_w=1 with reg_dst=1 and alu_op=0 in cycle 3, retired=1 after cycle 3.
- lw with mem_rdy low for 2 cycles -> mem_r=1 for 3 cycles, reg_w=1 with mem2r=1 in cycle 6, total 7 cycles.
- beq with zero=1 -> pc_wr=1, npc_op=01 in cycle 2. Same with zero=0 -> pc_wr=0, FETCH follows, retired still increments.
- ori then lui -> ext_op=00/alu_op=3 for ori, then ext_op=10/alu_op=5 for lui, reg_dst=0 in both WB_ALU cycles.
- op=111111 -> illegal=1 from the cycle after DECODE, all enables 0 for 10+ cycles, retired unchanged. rst clears both.
- sw stalled (mem_rdy=0), rst pulsed asynchronously mid-cycle -> mem_w drops before the next edge, state=FETCH, retired=0.
